// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RV32I front end.
// FETCH_MISALIGN_EN adds the HALT state used after a misaligned redirect.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DISCARD
`ifdef FETCH_MISALIGN_EN
        ,
        ST_HALT
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {instr, pc} entries; power-of-2 depth, single-cycle flush.
module fetch_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [DATA_W-1:0]              push_data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [DATA_W-1:0]              head_o,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: single-outstanding imem reads, prefetch FIFO, redirect flush.
// Optional FETCH_MISALIGN_EN: misaligned redirect raises sticky fault_o and halts fetch.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   req_addr_q, req_addr_d;
    logic               req_q, req_d;
    logic               fault_q, fault_d;

    logic [CNT_W-1:0]   count, count_d;
    logic [2*WIDTH-1:0] head;
    logic               grant, push, pop;
    logic [WIDTH-1:0]   target;
    logic               misalign;

    assign grant = req_q && imem_ready;
    assign pop   = instr_valid && instr_ready && !redirect_en;

`ifdef FETCH_MISALIGN_EN
    assign target   = redirect_pc;
    assign misalign = (redirect_pc[1:0] != 2'b00);
`else
    assign target   = redirect_pc & ~WIDTH'(INSTR_BYTES - 1);
    assign misalign = 1'b0;
`endif

    // Next-state, PC advance, FIFO push and registered request computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        fault_d    = fault_q;
        push       = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (grant) begin
                    pc_d       = pc_q + WIDTH'(INSTR_BYTES);
                    req_addr_d = pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) state_d = ST_FETCH;
            end
`ifdef FETCH_MISALIGN_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_FETCH;
        endcase

        // Redirect overrides everything: the one in-flight response (if any) must be dropped.
        if (redirect_en) begin
            push = 1'b0;
            pc_d = target;
            unique case (state_q)
                ST_FETCH:   state_d = grant ? ST_DISCARD : ST_FETCH;
                ST_WAIT:    state_d = imem_rvalid ? ST_FETCH : ST_DISCARD;
                ST_DISCARD: state_d = imem_rvalid ? ST_FETCH : ST_DISCARD;
`ifdef FETCH_MISALIGN_EN
                ST_HALT:    state_d = ST_HALT;
`endif
                default:    state_d = ST_FETCH;
            endcase
`ifdef FETCH_MISALIGN_EN
            if (misalign) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
`endif
        end

        if (redirect_en) begin
            count_d = '0;
        end else begin
            count_d = count + CNT_W'(push) - CNT_W'(pop);
        end
        req_d = (state_d == ST_FETCH) && (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            fault_q    <= fault_d || misalign && redirect_en && 1'b0;
        end
    end

    fetch_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({imem_rdata, req_addr_q}),
        .pop_i       (pop),
        .flush_i     (redirect_en),
        .head_o      (head),
        .count_o     (count)
    );

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (count != '0);
    assign instr_o     = instr_valid ? head[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
    assign instr_pc    = head[WIDTH-1:0];
    assign fault_o     = fault_q;

endmodule
